// File: rtl/thunderbird_seq_param_if.sv
// Switch-input / lamp-output bundle for the parametrised Thunderbird tail-light sequencer.
interface thunderbird_seq_param_if #(
  parameter int unsigned N_LAMPS = 3,
  parameter int unsigned SW      = $clog2(N_LAMPS + 1)
);
  logic               L;
  logic               R;
  logic               H;
  logic               B;
  logic [N_LAMPS-1:0] left;
  logic [N_LAMPS-1:0] right;
  logic [1:0]         mode;
  logic [SW-1:0]      step;

  modport master (output L, R, H, B, input left, right, mode, step);
  modport slave  (input L, R, H, B, output left, right, mode, step);
endinterface

// File: rtl/thunderbird_seq_param.sv
// Sequential-fill turn/hazard/brake tail-light controller with N_LAMPS per side
// and a DIV+1 clock step prescaler.
module thunderbird_seq_param #(
  parameter int unsigned N_LAMPS = 3,
  parameter int unsigned DIV     = 0,
  parameter int unsigned SW      = $clog2(N_LAMPS + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  thunderbird_seq_param_if.slave     bus
);

  localparam int unsigned CW = (DIV > 0) ? $clog2(DIV + 1) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2,
    HAZ   = 2'd3
  } mode_t;

  mode_t              mode_q, mode_n;
  logic [SW-1:0]      step_q, step_n;
  logic [CW-1:0]      cnt;
  logic               tick;
  logic               req_haz;
  logic [N_LAMPS-1:0] left_q, right_q, left_n, right_n;

  // Thermometer pattern: lamps below the step index are lit.
  function automatic logic [N_LAMPS-1:0] fill(input logic [SW-1:0] s);
    logic [N_LAMPS-1:0] f;
    f = '0;
    for (int i = 0; i < int'(N_LAMPS); i++) begin
      f[i] = (i < int'(s));
    end
    return f;
  endfunction

  assign tick    = (cnt == CW'(DIV));
  assign req_haz = bus.H | (bus.L & bus.R);

  // Next mode/step; only moves on prescaler ticks.
  always_comb begin
    mode_n = mode_q;
    step_n = step_q;
    if (tick) begin
      unique case (mode_q)
        IDLE: begin
          if (req_haz) begin
            mode_n = HAZ;   step_n = SW'(1);
          end else if (bus.L) begin
            mode_n = LEFT;  step_n = SW'(1);
          end else if (bus.R) begin
            mode_n = RIGHT; step_n = SW'(1);
          end else begin
            mode_n = IDLE;  step_n = '0;
          end
        end
        LEFT, RIGHT: begin
          if (req_haz) begin
            mode_n = HAZ;   step_n = SW'(1);
          end else if (step_q < SW'(N_LAMPS)) begin
            step_n = step_q + SW'(1);
          end else begin
            mode_n = IDLE;  step_n = '0;
          end
        end
        HAZ: begin
          if (step_q == SW'(1)) begin
            step_n = '0;
          end else if (req_haz) begin
            step_n = SW'(1);
          end else begin
            mode_n = IDLE;  step_n = '0;
          end
        end
        default: begin
          mode_n = IDLE;    step_n = '0;
        end
      endcase
    end
  end

  // Lamp decode of the next state, so the lamp registers line up with mode/step;
  // brake is folded in here, giving one clock from B to the lamps.
  always_comb begin
    left_n  = {N_LAMPS{bus.B}};
    right_n = {N_LAMPS{bus.B}};
    unique case (mode_n)
      LEFT:    left_n  = fill(step_n);
      RIGHT:   right_n = fill(step_n);
      HAZ: begin
        left_n  = {N_LAMPS{step_n[0]}};
        right_n = {N_LAMPS{step_n[0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      mode_q  <= IDLE;
      step_q  <= '0;
      left_q  <= '0;
      right_q <= '0;
    end else begin
      cnt     <= tick ? '0 : cnt + CW'(1);
      mode_q  <= mode_n;
      step_q  <= step_n;
      left_q  <= left_n;
      right_q <= right_n;
    end
  end

  assign bus.left  = left_q;
  assign bus.right = right_q;
  assign bus.mode  = mode_q;
  assign bus.step  = step_q;

endmodule

// File: tb/tb_thunderbird_seq_param.sv
// Directed bench for thunderbird_seq_param: N_LAMPS=3/DIV=0 and N_LAMPS=5/DIV=2 instances.
module tb_thunderbird_seq_param;

  logic clk;
  logic reset;
  int   vecs;
  int   miss;

  thunderbird_seq_param_if #(.N_LAMPS(3)) i3 ();
  thunderbird_seq_param_if #(.N_LAMPS(5)) i5 ();

  thunderbird_seq_param #(.N_LAMPS(3), .DIV(0)) dut3 (.clk(clk), .reset(reset), .bus(i3));
  thunderbird_seq_param #(.N_LAMPS(5), .DIV(2)) dut5 (.clk(clk), .reset(reset), .bus(i5));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle away from it.
  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    edge1();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    i3.L = 0; i3.R = 0; i3.H = 0; i3.B = 0;
    i5.L = 0; i5.R = 0; i5.H = 0; i5.B = 0;
    do_reset();
    vecs++; if (i3.left !== 3'b000) begin miss++; $display("FAIL reset left3 got=%b exp=000", i3.left); end
    vecs++; if (i3.right !== 3'b000) begin miss++; $display("FAIL reset right3 got=%b exp=000", i3.right); end
    vecs++; if (i3.mode !== 2'd0) begin miss++; $display("FAIL reset mode3 got=%0d exp=0", i3.mode); end
    vecs++; if (i3.step !== 2'd0) begin miss++; $display("FAIL reset step3 got=%0d exp=0", i3.step); end
    vecs++; if (i5.left !== 5'b00000 || i5.right !== 5'b00000) begin miss++; $display("FAIL reset lamps5 got=%b/%b exp=00000/00000", i5.left, i5.right); end
  endtask

  task automatic test_left_fill();
    logic [2:0] el[5] = '{3'b001, 3'b011, 3'b111, 3'b000, 3'b001};
    logic [1:0] em[5] = '{2'd1, 2'd1, 2'd1, 2'd0, 2'd1};
    do_reset();
    i3.L = 1;
    for (int k = 0; k < 5; k++) begin
      edge1();
      vecs++; if (i3.left !== el[k]) begin miss++; $display("FAIL left_fill[%0d] left got=%b exp=%b", k, i3.left, el[k]); end
      vecs++; if (i3.right !== 3'b000) begin miss++; $display("FAIL left_fill[%0d] right got=%b exp=000", k, i3.right); end
      vecs++; if (i3.mode !== em[k]) begin miss++; $display("FAIL left_fill[%0d] mode got=%0d exp=%0d", k, i3.mode, em[k]); end
    end
    i3.L = 0;
  endtask

  task automatic test_right_pulse();
    logic [2:0] er[6] = '{3'b001, 3'b011, 3'b111, 3'b000, 3'b000, 3'b000};
    logic [1:0] em[6] = '{2'd2, 2'd2, 2'd2, 2'd0, 2'd0, 2'd0};
    do_reset();
    i3.R = 1;
    for (int k = 0; k < 6; k++) begin
      edge1();
      i3.R = 0;
      vecs++; if (i3.right !== er[k]) begin miss++; $display("FAIL right_pulse[%0d] right got=%b exp=%b", k, i3.right, er[k]); end
      vecs++; if (i3.mode !== em[k]) begin miss++; $display("FAIL right_pulse[%0d] mode got=%0d exp=%0d", k, i3.mode, em[k]); end
    end
  endtask

  task automatic test_brake();
    // Fourth edge lands in IDLE, where the brake lights both sides.
    logic [2:0] el[4] = '{3'b001, 3'b011, 3'b111, 3'b111};
    do_reset();
    i3.L = 1; i3.B = 1;
    for (int k = 0; k < 4; k++) begin
      edge1();
      vecs++; if (i3.left !== el[k]) begin miss++; $display("FAIL brake[%0d] left got=%b exp=%b", k, i3.left, el[k]); end
      vecs++; if (i3.right !== 3'b111) begin miss++; $display("FAIL brake[%0d] right got=%b exp=111", k, i3.right); end
    end
    i3.L = 0; i3.B = 0;
    edge1();
    vecs++; if (i3.right !== 3'b000 || i3.left !== 3'b000) begin miss++; $display("FAIL brake_release lamps got=%b/%b exp=000/000", i3.left, i3.right); end
    vecs++; if (i3.mode !== 2'd0) begin miss++; $display("FAIL brake_release mode got=%0d exp=0", i3.mode); end
  endtask

  task automatic test_hazard_preempt();
    do_reset();
    i3.L = 1;
    edge1();
    edge1();
    vecs++; if (i3.left !== 3'b011) begin miss++; $display("FAIL preempt pre left got=%b exp=011", i3.left); end
    i3.R = 1; i3.B = 1;
    edge1();
    vecs++; if (i3.left !== 3'b111 || i3.right !== 3'b111) begin miss++; $display("FAIL preempt on lamps got=%b/%b exp=111/111", i3.left, i3.right); end
    vecs++; if (i3.mode !== 2'd3 || i3.step !== 2'd1) begin miss++; $display("FAIL preempt on mode/step got=%0d/%0d exp=3/1", i3.mode, i3.step); end
    i3.L = 0; i3.R = 0;
    edge1();
    // Brake is ignored during the hazard off phase.
    vecs++; if (i3.left !== 3'b000 || i3.right !== 3'b000) begin miss++; $display("FAIL preempt off lamps got=%b/%b exp=000/000", i3.left, i3.right); end
    vecs++; if (i3.mode !== 2'd3) begin miss++; $display("FAIL preempt off mode got=%0d exp=3", i3.mode); end
    i3.B = 0;
    edge1();
    vecs++; if (i3.mode !== 2'd0 || i3.step !== 2'd0) begin miss++; $display("FAIL preempt exit mode/step got=%0d/%0d exp=0/0", i3.mode, i3.step); end
  endtask

  task automatic test_hazard_div();
    logic       on;
    logic [4:0] exp_l;
    logic [1:0] exp_m;
    logic [2:0] exp_s;
    do_reset();
    i5.H = 1;
    for (int k = 1; k <= 12; k++) begin
      edge1();
      on    = (k >= 3) && (((k / 3) % 2) == 1);
      exp_l = on ? 5'b11111 : 5'b00000;
      exp_m = (k >= 3) ? 2'd3 : 2'd0;
      exp_s = on ? 3'd1 : 3'd0;
      vecs++; if (i5.left !== exp_l || i5.right !== exp_l) begin miss++; $display("FAIL haz_div[%0d] lamps got=%b/%b exp=%b", k, i5.left, i5.right, exp_l); end
      vecs++; if (i5.mode !== exp_m || i5.step !== exp_s) begin miss++; $display("FAIL haz_div[%0d] mode/step got=%0d/%0d exp=%0d/%0d", k, i5.mode, i5.step, exp_m, exp_s); end
    end
    i5.H = 0;
    edge1(); edge1();
    vecs++; if (i5.mode !== 2'd3) begin miss++; $display("FAIL haz_div hold mode got=%0d exp=3", i5.mode); end
    edge1();
    vecs++; if (i5.mode !== 2'd0 || i5.left !== 5'b00000) begin miss++; $display("FAIL haz_div exit mode/left got=%0d/%b exp=0/00000", i5.mode, i5.left); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    i3.L = 1;
    edge1();
    edge1();
    vecs++; if (i3.left !== 3'b011) begin miss++; $display("FAIL reset_mid pre left got=%b exp=011", i3.left); end
    reset = 1;
    edge1();
    reset = 0;
    vecs++; if (i3.mode !== 2'd0 || i3.left !== 3'b000 || i3.step !== 2'd0) begin miss++; $display("FAIL reset_mid mode/left/step got=%0d/%b/%0d exp=0/000/0", i3.mode, i3.left, i3.step); end
    edge1();
    vecs++; if (i3.mode !== 2'd1 || i3.left !== 3'b001) begin miss++; $display("FAIL reset_mid restart mode/left got=%0d/%b exp=1/001", i3.mode, i3.left); end
    i3.L = 0;
  endtask

  initial begin
    vecs  = 0;
    miss  = 0;
    reset = 1'b0;
    test_reset();
    test_left_fill();
    test_right_pulse();
    test_brake();
    test_hazard_preempt();
    test_hazard_div();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
